// File: rtl/ps2_scan_tx.sv
// PS/2 device-side transmitter: frames one scan code (start, 8 data LSB first, odd parity, stop)
// and drives the open-drain clock/data lines. Define PS2_TX_INHIBIT_EN to honour host inhibit.
module ps2_scan_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_HALVES  = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       abort
);

  localparam int GAP_CYCLES = GAP_HALVES * HALF_PERIOD;
  localparam int CNT_MAX    = (GAP_CYCLES > HALF_PERIOD) ? GAP_CYCLES : HALF_PERIOD;
  localparam int CNT_W      = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HALF_LAST     = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_PRE_LAST = CNT_W'(HALF_PERIOD - 2);
  localparam logic [CNT_W-1:0] GAP_LAST      = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       STOP_BIT      = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INH, S_BIT_HIGH, S_BIT_LOW, S_GAP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;
  logic [10:0]      frame_q;
  logic [10:0]      frame_d;
  logic             in_ready_q, busy_q, clk_oe_q, dat_oe_q, done_q, abort_q;

  // Frame bit 0 goes on the wire first; parity is XNOR so data+parity has an odd ones count.
  assign frame_d = {1'b1, ~^in_data, in_data, 1'b0};

`ifdef PS2_TX_INHIBIT_EN
  logic [1:0] sync_q;
  logic       clk_high;

  always_ff @(posedge CLOCK_50) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], ps2_clk_in};
  end
  assign clk_high = sync_q[1];
`else
  logic unused_ps2_clk;
  assign unused_ps2_clk = ps2_clk_in;
`endif

  // NOTE: all state here uses non-blocking assignments, so a later assignment in the same
  // branch cleanly overrides an earlier default without creating ordering hazards.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            frame_q    <= frame_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
`ifdef PS2_TX_INHIBIT_EN
            state_q    <= S_WAIT_INH;
`else
            state_q    <= S_BIT_HIGH;
            dat_oe_q   <= 1'b1;
`endif
          end
        end
`ifdef PS2_TX_INHIBIT_EN
        S_WAIT_INH: begin
          if (!clk_high) begin
            cnt_q <= '0;
          end else if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            state_q  <= S_BIT_HIGH;
            dat_oe_q <= ~frame_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_BIT_HIGH: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            state_q  <= S_BIT_LOW;
            clk_oe_q <= 1'b1;
`ifdef PS2_TX_INHIBIT_EN
            // Host holding the clock low before we pull it: back off and resend from the start bit.
            if (!clk_high && bit_q != STOP_BIT) begin
              state_q  <= S_WAIT_INH;
              clk_oe_q <= 1'b0;
              dat_oe_q <= 1'b0;
              bit_q    <= '0;
              abort_q  <= 1'b1;
            end
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_BIT_LOW: begin
          if (cnt_q == HALF_PRE_LAST && bit_q == STOP_BIT) done_q <= 1'b1;
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            clk_oe_q <= 1'b0;
            if (bit_q == STOP_BIT) begin
              dat_oe_q <= 1'b0;
              if (GAP_CYCLES == 0) begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                in_ready_q <= 1'b1;
              end else begin
                state_q <= S_GAP;
              end
            end else begin
              bit_q    <= bit_q + 4'd1;
              state_q  <= S_BIT_HIGH;
              dat_oe_q <= ~frame_q[bit_q + 4'd1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign abort      = abort_q;

endmodule
